// File: rtl/bcd_timer_ctrl_if.sv
// Command/status bundle between user logic, the countdown sequencer and the
// BCD digit counter chain. The master side owns the commands and the counter
// readback; the slave side is the sequencer itself.
interface bcd_timer_ctrl_if #(
  parameter int DIGITS = 2
);
  logic                  start;
  logic                  pause;
  logic                  stop;
  logic [4*DIGITS-1:0]   preset;
  logic [4*DIGITS-1:0]   q_in;
  logic [4*DIGITS-1:0]   cnt_d;
  logic                  cnt_load;
  logic                  cnt_up;
  logic [DIGITS-1:0]     dig_en;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, pause, stop, preset, q_in,
    input  cnt_d, cnt_load, cnt_up, dig_en, busy, done, err
  );

  modport slave (
    input  start, pause, stop, preset, q_in,
    output cnt_d, cnt_load, cnt_up, dig_en, busy, done, err
  );
endinterface

// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: countdown sequencer for a chain of DIGITS BCD counters.
// Latches a validated BCD preset, loads it into the chain, then decrements the
// chain once every TICK_DIV clocks through per-digit enables (borrow chain)
// until every digit reads zero.
// Optional build macro: BCD_TIMER_AUTORELOAD_EN -- DONE lasts one cycle and
// the held preset is reloaded automatically (stop still returns to IDLE).
module bcd_timer_ctrl #(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 10
) (
  input logic             clk,
  input logic             clr,
  bcd_timer_ctrl_if.slave bus
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [PW-1:0]   presc_q;
  logic [PW-1:0]   presc_d;
  logic [W-1:0]    preset_q;
  logic [W-1:0]    preset_d;
  logic            cnt_load_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic            err_d;

  logic            tick_s;
  logic            q_zero_s;
  logic            start_err_s;
  state_t          start_state_s;
  logic [DIGITS-1:0] dig_en_s;
  logic            borrow_s;

  // True when every nibble of the value is a legal BCD digit (0..9).
  function automatic logic bcd_valid(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  assign tick_s   = (state_q == S_RUN) && (presc_q == PRESC_LAST);
  assign q_zero_s = (bus.q_in == {W{1'b0}});

  // Outcome of a start command: reject bad BCD, finish at once on zero, else load.
  always_comb begin
    start_err_s   = 1'b0;
    start_state_s = S_IDLE;
    if (!bcd_valid(bus.preset)) begin
      start_err_s   = 1'b1;
      start_state_s = S_IDLE;
    end else if (bus.preset == {W{1'b0}}) begin
      start_state_s = S_DONE;
    end else begin
      start_state_s = S_LOAD;
    end
  end

  // Next-state logic; command priority is stop, then pause, then start.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    preset_d = preset_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.stop || bus.pause || !bus.start) begin
          state_d = S_IDLE;
        end else begin
          state_d = start_state_s;
          err_d   = start_err_s;
          if (start_state_s == S_LOAD) begin
            preset_d = bus.preset;
          end else begin
            preset_d = preset_q;
          end
        end
      end
      S_LOAD: begin
        presc_d = {PW{1'b0}};
        if (bus.stop) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (tick_s) begin
          presc_d = {PW{1'b0}};
        end else begin
          presc_d = presc_q + PW'(1);
        end
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (bus.pause) begin
          state_d = S_PAUSE;
        end else if (!tick_s && q_zero_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_PAUSE: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (bus.pause) begin
          state_d = S_PAUSE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
`ifdef BCD_TIMER_AUTORELOAD_EN
        if (bus.stop) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_LOAD;
        end
`else
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (bus.pause || !bus.start) begin
          state_d = S_DONE;
        end else begin
          state_d = start_state_s;
          err_d   = start_err_s;
          if (start_state_s == S_LOAD) begin
            preset_d = bus.preset;
          end else begin
            preset_d = preset_q;
          end
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
        presc_d = {PW{1'b0}};
      end
    endcase
  end

  // State, prescaler, preset register and registered state-decoded outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= S_IDLE;
      presc_q    <= {PW{1'b0}};
      preset_q   <= {W{1'b0}};
      cnt_load_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      preset_q   <= preset_d;
      cnt_load_q <= (state_d == S_LOAD);
      busy_q     <= (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_PAUSE);
      done_q     <= (state_d == S_DONE);
      err_q      <= err_d;
    end
  end

  // Digit enables: all digits during load, borrow chain on a run tick, else none.
  always_comb begin
    dig_en_s = {DIGITS{1'b0}};
    borrow_s = 1'b1;
    if (state_q == S_LOAD) begin
      dig_en_s = {DIGITS{1'b1}};
    end else if (tick_s) begin
      for (int i = 0; i < DIGITS; i++) begin
        dig_en_s[i] = borrow_s;
        borrow_s    = borrow_s & (bus.q_in[4*i +: 4] == 4'd0);
      end
    end else begin
      dig_en_s = {DIGITS{1'b0}};
    end
  end

  assign bus.cnt_d    = preset_q;
  assign bus.cnt_load = cnt_load_q;
  assign bus.cnt_up   = 1'b0;
  assign bus.dig_en   = dig_en_s;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Bench for bcd_timer_ctrl: models the BCD digit counter chain and predicts
// every output from the countdown arithmetic (tick times, remaining value,
// borrow pattern as value mod 10^i) rather than from a state machine.
module tb_bcd_timer_ctrl;
  localparam int DIGITS   = 2;
  localparam int TICK_DIV = 4;
  localparam int W        = 4 * DIGITS;

  logic clk = 1'b0;
  logic clr;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [W-1:0] q_r;

  bcd_timer_ctrl_if #(.DIGITS(DIGITS)) bus ();

  bcd_timer_ctrl #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural BCD down-counter chain fed by the sequencer.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q_r <= '0;
    end else if (bus.cnt_load) begin
      q_r <= bus.cnt_d;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (bus.dig_en[i]) q_r[4*i +: 4] <= (q_r[4*i +: 4] == 4'd0) ? 4'd9 : q_r[4*i +: 4] - 4'd1;
      end
    end
  end
  assign bus.q_in = q_r;

  function automatic int bcd2int(input logic [W-1:0] b);
    int r, m;
    r = 0; m = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r = r + int'(b[4*i +: 4]) * m;
      m = m * 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r;
    int m;
    m = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / m) % 10);
      m = m * 10;
    end
    return r;
  endfunction

  // Digit i decrements on a tick iff the lower i digits are all zero.
  function automatic logic [DIGITS-1:0] exp_en(input int qv);
    logic [DIGITS-1:0] r;
    int m;
    m = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[i] = ((qv % m) == 0);
      m = m * 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] pack(input logic ld, input logic bz, input logic dn,
                                       input logic er, input logic [DIGITS-1:0] en);
    return 32'({ld, bz, dn, er, en});
  endfunction

  function automatic logic [31:0] outs();
    return 32'({bus.cnt_load, bus.busy, bus.done, bus.err, bus.dig_en});
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Start preset p, optionally hold pause high for cycles jp..jp+plen-1
  // (cycle 1 = LOAD cycle), and check every cycle up to expiry.
  task automatic run_preset(input logic [W-1:0] p, input int jp, input int plen);
    int v, last, je, qv;
    logic tick, chk_q;
    logic [31:0] exp_v;
    v = bcd2int(p);
    @(negedge clk);
    bus.preset = p;
    bus.start  = 1'b1;
    last = 3 + v * TICK_DIV + plen;
`ifndef BCD_TIMER_AUTORELOAD_EN
    last = last + 1;
`endif
    for (int j = 1; j <= last; j++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.pause = (plen > 0) && (j >= jp) && (j < jp + plen);
      qv = 0;
      chk_q = 1'b1;
      if ((plen > 0) && (j > jp) && (j <= jp + plen)) begin
        exp_v = pack(1'b0, 1'b1, 1'b0, 1'b0, {DIGITS{1'b0}});
        qv    = v - (jp - 1) / TICK_DIV;
      end else begin
        je = ((plen > 0) && (j > jp + plen)) ? j - plen : j;
        if (je == 1) begin
          exp_v = pack(1'b1, 1'b1, 1'b0, 1'b0, {DIGITS{1'b1}});
          chk_q = 1'b0;
          check("cnt_d_load", 32'(bus.cnt_d), 32'(p));
        end else if (je <= 2 + v * TICK_DIV) begin
          qv    = v - (je - 2) / TICK_DIV;
          tick  = (((je - 1) % TICK_DIV) == 0) && (je <= 1 + v * TICK_DIV);
          exp_v = pack(1'b0, 1'b1, 1'b0, 1'b0, tick ? exp_en(qv) : {DIGITS{1'b0}});
        end else begin
          exp_v = pack(1'b0, 1'b0, 1'b1, 1'b0, {DIGITS{1'b0}});
        end
      end
      check($sformatf("run p=%0h c=%0d outs", p, j), outs(), exp_v);
      if (chk_q) check($sformatf("run p=%0h c=%0d q", p, j), 32'(bcd2int(q_r)), 32'(qv));
    end
    bus.pause = 1'b0;
  endtask

  task automatic stop_to_idle(input string tag);
    @(negedge clk);
    bus.stop  = 1'b1;
    bus.pause = 1'b0;
    @(negedge clk);
    bus.stop = 1'b0;
    check(tag, outs(), pack(1'b0, 1'b0, 1'b0, 1'b0, {DIGITS{1'b0}}));
  endtask

  task automatic err_check(input logic [W-1:0] p, input string tag);
    @(negedge clk);
    bus.preset = p;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_pulse"}, outs(), pack(1'b0, 1'b0, 1'b0, 1'b1, {DIGITS{1'b0}}));
    @(negedge clk);
    check({tag, "_after"}, outs(), pack(1'b0, 1'b0, 1'b0, 1'b0, {DIGITS{1'b0}}));
  endtask

  initial begin
    logic [W-1:0] p;
    int v, nib;
    bus.start  = 1'b0;
    bus.pause  = 1'b0;
    bus.stop   = 1'b0;
    bus.preset = '0;
    clr = 1'b1;
    #1 clr = 1'b0;
    #2;
    check("reset_outs", outs(), pack(1'b0, 1'b0, 1'b0, 1'b0, {DIGITS{1'b0}}));
    check("reset_cnt_d", 32'(bus.cnt_d), 32'h0);
    check("reset_cnt_up", 32'(bus.cnt_up), 32'h0);
    repeat (2) @(negedge clk);
    clr = 1'b1;

    // Main directed case: preset 12, ticks with borrow at q=10.
    run_preset(8'h12, 0, 0);
    stop_to_idle("stop_after_12");

    // Rejected presets.
    err_check(8'h1A, "err_1A");
    for (int k = 0; k < 3; k++) begin
      v   = $urandom_range(0, 99);
      p   = int2bcd(v);
      nib = $urandom_range(0, DIGITS - 1);
      p[4*nib +: 4] = 4'(10 + $urandom_range(0, 5));
      err_check(p, $sformatf("err_rand_%0h", p));
    end

    // Zero preset finishes immediately without a load.
    @(negedge clk);
    bus.preset = 8'h00;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("zero_done", outs(), pack(1'b0, 1'b0, 1'b1, 1'b0, {DIGITS{1'b0}}));
`ifndef BCD_TIMER_AUTORELOAD_EN
    @(negedge clk);
    check("zero_hold", outs(), pack(1'b0, 1'b0, 1'b1, 1'b0, {DIGITS{1'b0}}));
    // stop and start together in DONE: stop wins.
    bus.preset = 8'h05;
    bus.start  = 1'b1;
    bus.stop   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("stop_start_done", outs(), pack(1'b0, 1'b0, 1'b0, 1'b0, {DIGITS{1'b0}}));
    @(negedge clk);
    check("stop_start_idle", outs(), pack(1'b0, 1'b0, 1'b0, 1'b0, {DIGITS{1'b0}}));
`else
    stop_to_idle("stop_after_zero");
`endif

    // Directed pause: 10 cycles with the prescaler held at 2.
    run_preset(8'h12, 7, 10);
    stop_to_idle("stop_after_pause");

    // Randomized presets, some with a randomized pause window.
    for (int k = 0; k < 4; k++) begin
      v = $urandom_range(1, 40);
      if (k % 2 == 1) run_preset(int2bcd(v), $urandom_range(2, 1 + v * TICK_DIV), $urandom_range(1, 6));
      else            run_preset(int2bcd(v), 0, 0);
      stop_to_idle($sformatf("stop_after_rand_%0d", k));
    end

    // stop together with pause mid-run aborts to IDLE.
    @(negedge clk);
    bus.preset = 8'h30;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    bus.stop  = 1'b1;
    bus.pause = 1'b1;
    @(negedge clk);
    bus.stop  = 1'b0;
    bus.pause = 1'b0;
    check("stop_pause_run", outs(), pack(1'b0, 1'b0, 1'b0, 1'b0, {DIGITS{1'b0}}));

    // Asynchronous reset mid-run, then a clean restart.
    @(negedge clk);
    bus.preset = 8'h25;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #2 clr = 1'b0;
    #1;
    check("clr_mid_outs", outs(), pack(1'b0, 1'b0, 1'b0, 1'b0, {DIGITS{1'b0}}));
    check("clr_mid_cnt_d", 32'(bus.cnt_d), 32'h0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    check("clr_release_idle", outs(), pack(1'b0, 1'b0, 1'b0, 1'b0, {DIGITS{1'b0}}));
    run_preset(int2bcd($urandom_range(1, 30)), 0, 0);
    stop_to_idle("stop_after_restart");

`ifdef BCD_TIMER_AUTORELOAD_EN
    begin : autoreload_chk
      int done_at[$];
      @(negedge clk);
      bus.preset = 8'h03;
      bus.start  = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int c = 1; c <= 60; c++) begin
        if (c > 1) @(negedge clk);
        if (bus.done === 1'b1) done_at.push_back(c);
      end
      check("ar_pulse_count", 32'(done_at.size()), 32'd4);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("ar_pulse_%0d", k), 32'(done_at[k]), 32'(15 + 15 * k));
      end
      stop_to_idle("ar_stop");
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
